dm_wb_cache: RTL and testbench
==============================

// Module: dm_wb_cache
// PURPOSE
//  Parametrised direct-mapped, write-back, write-allocate data cache between the single-cycle MIPS
//  core and line-wide Data_Memory. Successor to the fixed 32-line x 256-bit cache: geometry is
//  generic, valid/dirty state is cleared by hardware reset, and it adds a flush engine, a
//  dirty-victim writeback path and hit/miss counters.
// PARAMETERS
//  ADDR_W      32  byte address width
//  WORD_W      32  CPU word width (bits)
//  LINE_WORDS   8  words per line; LINE_W = LINE_WORDS*WORD_W (256 by default)
//  LINES       32  number of lines (power of 2)
//  derived: OFF_W = log2(LINE_WORDS*WORD_W/8), IDX_W = log2(LINES), TAG_W = ADDR_W-IDX_W-OFF_W
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  cpu_req     in   1       access request, sampled only in IDLE
//  cpu_we      in   1       1 = store word, 0 = load word
//  cpu_addr    in   ADDR_W  byte address; bits [1:0] ignored
//  cpu_wdata   in   WORD_W  store data
//  cpu_rdata   out  WORD_W  load data, valid while cpu_ready=1
//  cpu_ready   out  1       one-cycle completion pulse
//  cpu_busy    out  1       1 in every state except IDLE
//  flush       in   1       write back all dirty lines, sampled in IDLE
//  flush_done  out  1       one-cycle pulse when flush completes
//  mem_req     out  1       memory transaction request, held until mem_ack
//  mem_we      out  1       1 = line write (writeback), 0 = line read (refill)
//  mem_addr    out  ADDR_W  line-aligned address, low OFF_W bits = 0
//  mem_wdata   out  LINE_W  victim line data
//  mem_rdata   in   LINE_W  refill data, valid when mem_ack=1
//  mem_ack     in   1       one-cycle transaction acknowledge
//  hit_cnt     out  32      load/store hits since reset, saturating
//  miss_cnt    out  32      load/store misses since reset, saturating
// BEHAVIOUR
//  Reset: state=IDLE; all valid and dirty bits=0; cpu_ready, flush_done, mem_req, mem_we=0;
//   cpu_rdata, mem_addr, mem_wdata=0; counters=0. Tag and data RAMs are not cleared.
//   Reset mid-transaction aborts at once: mem_req falls asynchronously and no line is updated.
//  Address split: tag=addr[ADDR_W-1:IDX_W+OFF_W], idx=addr[IDX_W+OFF_W-1:OFF_W],
//   word=addr[OFF_W-1:2].
//  FSM:
//   IDLE:   flush=1 -> FLUSH, idx counter=0 (flush wins over a simultaneous cpu_req).
//           Else cpu_req=1 -> latch addr/we/wdata, go to LOOKUP.
//   LOOKUP: hit = valid[idx] & tag match.
//           Hit: load drives cpu_rdata=line[word]; store writes the word and sets dirty=1.
//             cpu_ready=1 for the next cycle, then IDLE. hit_cnt+1 unless this is the replay.
//           Miss: miss_cnt+1. If valid & dirty -> WRITEBACK, else -> REFILL.
//   WRITEBACK: mem_req=1, mem_we=1, mem_addr={old tag,idx,0}, mem_wdata=victim line.
//           On mem_ack -> REFILL.
//   REFILL: mem_req=1, mem_we=0, mem_addr={tag,idx,0}. On mem_ack: line=mem_rdata,
//           tag written, valid=1, dirty=0, then LOOKUP again (the replay, which always hits).
//   FLUSH:  for each idx 0..LINES-1: if valid & dirty, write the line back (same handshake
//           as WRITEBACK) and clear dirty on mem_ack; else skip in 1 cycle. After the
//           last idx: flush_done=1 for one cycle, then IDLE. Valid bits are unchanged.
//  Latency: a hit sampled at edge N gives cpu_ready high in the cycle after edge N+2.
//   A miss adds the memory handshake cycles plus one replay LOOKUP.
//  Handshake: mem_req, mem_we, mem_addr and mem_wdata stay stable from assertion until the
//   edge that samples mem_ack=1. mem_req drops the cycle after that. mem_ack outside a
//   request is ignored. cpu_req and flush are ignored while busy.
//  Counters saturate at 32'hFFFF_FFFF. A replay LOOKUP counts as neither hit nor miss.
// TESTING
//  1 After reset, load 0x0000_0040 -> read req to line 0x40. Return words 11..18 ->
//    cpu_rdata=11, miss_cnt=1. Load 0x44 -> 12 with no mem_req, hit_cnt=1.
//  2 Store 0x48=0xDEADBEEF (hit), then load 0x48 -> 0xDEADBEEF, no memory traffic, hit_cnt=3.
//  3 Load 0x0000_0440 (same idx 2) -> write to 0x40 with word2=0xDEADBEEF, then read 0x440.
//    Return 0x21.. -> cpu_rdata=0x21, miss_cnt=2.
//  4 Dirty idx 3 and idx 7, then pulse flush -> exactly 2 writes (0x60, 0xE0), flush_done
//    pulses once. A second flush -> 0 writes, flush_done after LINES cycles.
//  5 Assert rst during REFILL with mem_req=1 -> mem_req=0 before the next edge. Re-load 0x44
//    -> miss (all lines invalid), counters restart at 0.
//  6 Delay mem_ack 5 cycles -> cpu_busy held at 1, mem_* stable; cpu_req pulses meanwhile
//    are ignored.

Source files
------------

// File: rtl/dm_wb_cache.sv
// dm_wb_cache: direct-mapped write-back write-allocate data cache with flush engine and hit/miss counters
module dm_wb_cache #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 8,
  parameter int LINES      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [WORD_W-1:0]            cpu_wdata,
  output logic [WORD_W-1:0]            cpu_rdata,
  output logic                         cpu_ready,
  output logic                         cpu_busy,
  input  logic                         flush,
  output logic                         flush_done,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [LINE_WORDS*WORD_W-1:0] mem_wdata,
  input  logic [LINE_WORDS*WORD_W-1:0] mem_rdata,
  input  logic                         mem_ack,
  output logic [31:0]                  hit_cnt,
  output logic [31:0]                  miss_cnt
);
  localparam int LINE_W = LINE_WORDS * WORD_W;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WSEL_W = OFF_W - 2;
  typedef enum logic [2:0] {IDLE, LOOKUP, RESP, WB, REFILL, FLUSH, FLUSH_WB} state_t;
  state_t state, nxt;
  logic [TAG_W-1:0]  a_tag;
  logic [IDX_W-1:0]  a_idx, fidx;
  logic [WSEL_W-1:0] a_word;
  logic [WORD_W-1:0] a_wdata;
  logic              a_we, replay;
  logic [LINES-1:0]  valid, dirty;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [LINE_W-1:0] lines [LINES];
  logic              hit, victim, f_dirty, f_last;
  logic              unused;
  assign unused = ^cpu_addr[1:0];
  always_comb begin
    hit      = valid[a_idx] && tags[a_idx] == a_tag;
    victim   = valid[a_idx] && dirty[a_idx];
    f_dirty  = valid[fidx] && dirty[fidx];
    f_last   = fidx == IDX_W'(LINES - 1);
    mem_req  = state == WB || state == REFILL || state == FLUSH_WB;
    cpu_busy = state != IDLE;
    nxt      = state;
    case (state)
      IDLE:     nxt = flush ? FLUSH : cpu_req ? LOOKUP : IDLE;
      LOOKUP:   nxt = hit ? RESP : victim ? WB : REFILL;
      RESP:     nxt = IDLE;
      WB:       nxt = mem_ack ? REFILL : WB;
      REFILL:   nxt = mem_ack ? LOOKUP : REFILL;
      FLUSH:    nxt = f_dirty ? FLUSH_WB : f_last ? IDLE : FLUSH;
      FLUSH_WB: nxt = !mem_ack ? FLUSH_WB : f_last ? IDLE : FLUSH;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;
  // tag and data arrays are deliberately left out of the reset branch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= '0;
      dirty      <= '0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      flush_done <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      fidx       <= '0;
      replay     <= 1'b0;
      a_tag      <= '0;
      a_idx      <= '0;
      a_word     <= '0;
      a_we       <= 1'b0;
      a_wdata    <= '0;
    end else begin
      cpu_ready  <= state == RESP;
      flush_done <= (state == FLUSH && !f_dirty && f_last) || (state == FLUSH_WB && mem_ack && f_last);
      case (state)
        IDLE:
          if (flush) fidx <= '0;
          else if (cpu_req) begin
            a_tag   <= cpu_addr[ADDR_W-1:IDX_W+OFF_W];
            a_idx   <= cpu_addr[IDX_W+OFF_W-1:OFF_W];
            a_word  <= cpu_addr[OFF_W-1:2];
            a_we    <= cpu_we;
            a_wdata <= cpu_wdata;
            replay  <= 1'b0;
          end
        LOOKUP:
          if (hit) begin
            if (!replay) hit_cnt <= hit_cnt + {31'b0, ~&hit_cnt};
            if (a_we) begin
              lines[a_idx][WORD_W*a_word +: WORD_W] <= a_wdata;
              dirty[a_idx] <= 1'b1;
            end else cpu_rdata <= lines[a_idx][WORD_W*a_word +: WORD_W];
          end else begin
            miss_cnt  <= miss_cnt + {31'b0, ~&miss_cnt};
            mem_we    <= victim;
            mem_addr  <= victim ? {tags[a_idx], a_idx, {OFF_W{1'b0}}} : {a_tag, a_idx, {OFF_W{1'b0}}};
            mem_wdata <= lines[a_idx];
          end
        WB:
          if (mem_ack) begin
            mem_we   <= 1'b0;
            mem_addr <= {a_tag, a_idx, {OFF_W{1'b0}}};
          end
        REFILL:
          if (mem_ack) begin
            lines[a_idx] <= mem_rdata;
            tags[a_idx]  <= a_tag;
            valid[a_idx] <= 1'b1;
            dirty[a_idx] <= 1'b0;
            replay       <= 1'b1;
          end
        FLUSH:
          if (f_dirty) begin
            mem_we    <= 1'b1;
            mem_addr  <= {tags[fidx], fidx, {OFF_W{1'b0}}};
            mem_wdata <= lines[fidx];
          end else fidx <= fidx + IDX_W'(1);
        FLUSH_WB:
          if (mem_ack) begin
            dirty[fidx] <= 1'b0;
            mem_we      <= 1'b0;
            fidx        <= fidx + IDX_W'(1);
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_wb_cache.sv
// tb_dm_wb_cache: scoreboard bench with a line-level memory model and a coherent CPU-view reference
module tb_dm_wb_cache;
  localparam int NL = 32;
  typedef struct {bit we; logic [31:0] a; logic [255:0] d;} mtx_t;
  typedef struct {bit ld; logic [31:0] d;} ctx_t;
  logic clk = 0, rst = 1;
  logic cpu_req = 0, cpu_we = 0, flush = 0, mem_ack = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic [255:0] mem_rdata = 0;
  logic [31:0] cpu_rdata, mem_addr, hit_cnt, miss_cnt;
  logic [255:0] mem_wdata;
  logic cpu_ready, cpu_busy, flush_done, mem_req, mem_we;
  dm_wb_cache dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy),
    .flush(flush), .flush_done(flush_done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );
  always #5 clk = ~clk;
  mtx_t mq[$];
  ctx_t cq[$];
  int fpend = 0, errs = 0, checks = 0, wr_cnt = 0, fixed_delay = -1;
  bit stall = 0;
  logic [255:0] rmem [logic [31:0]];
  logic [255:0] mmem [logic [31:0]];
  logic [31:0]  ov   [logic [31:0]];
  logic [31:0] res_a [NL];
  bit res_v [NL];
  bit res_d [NL];
  logic [31:0] hits = 0, misses = 0;
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [255:0] init_line(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++)
      l[k*32 +: 32] = (a == 32'h40) ? 32'(11 + k) : (a == 32'h440) ? 32'(33 + k) :
                      ((a + 32'(4 * k)) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    return l;
  endfunction
  function automatic logic [255:0] vline(input logic [31:0] la);
    logic [255:0] l;
    l = mmem.exists(la) ? mmem[la] : init_line(la);
    for (int k = 0; k < 8; k++)
      if (ov.exists(la + 32'(4 * k))) l[k*32 +: 32] = ov[la + 32'(4 * k)];
    return l;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin res_v[i] = 0; res_d[i] = 0; end
    ov.delete(); mq.delete(); cq.delete();
    hits = 0; misses = 0; fpend = 0;
  endtask
  task automatic model_wb(input int i);
    mtx_t t;
    t.we = 1; t.a = res_a[i]; t.d = vline(res_a[i]);
    mq.push_back(t);
    mmem[res_a[i]] = t.d;
    for (int k = 0; k < 8; k++) ov.delete(res_a[i] + 32'(4 * k));
    res_d[i] = 0;
  endtask
  task automatic model_access(input bit we, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] la;
    logic [255:0] l;
    int i, w;
    mtx_t t;
    ctx_t c;
    la = {a[31:5], 5'b0}; i = int'(a[9:5]); w = int'(a[4:2]);
    if (res_v[i] && res_a[i] == la) hits++;
    else begin
      misses++;
      if (res_v[i] && res_d[i]) model_wb(i);
      t.we = 0; t.a = la; t.d = 0;
      mq.push_back(t);
      res_v[i] = 1; res_a[i] = la; res_d[i] = 0;
    end
    c.ld = !we; c.d = 0;
    if (we) begin ov[{a[31:2], 2'b0}] = wd; res_d[i] = 1; end
    else begin l = vline(la); c.d = l[w*32 +: 32]; end
    cq.push_back(c);
  endtask
  task automatic op(input bit we, input logic [31:0] a, input logic [31:0] wd, output int cyc);
    int g = 0;
    while (cpu_busy && g < 200) begin @(negedge clk); g++; end
    model_access(we, a, wd);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    cyc = 0;
    do begin
      @(negedge clk);
      if (cyc == 0) cpu_req = 0;
      cyc++;
    end while (!cpu_ready && cyc < 400);
    check("cpu_ready", 256'(cpu_ready), 256'(1));
    check("hit_cnt", 256'(hit_cnt), 256'(hits));
    check("miss_cnt", 256'(miss_cnt), 256'(misses));
  endtask
  task automatic do_flush(output int cyc);
    int g = 0;
    while (cpu_busy && g < 200) begin @(negedge clk); g++; end
    for (int i = 0; i < NL; i++) if (res_v[i] && res_d[i]) model_wb(i);
    fpend++;
    flush = 1;
    cyc = 0;
    do begin
      @(negedge clk);
      if (cyc == 0) flush = 0;
      cyc++;
    end while (!flush_done && cyc < 2000);
    check("flush_done", 256'(flush_done), 256'(1));
  endtask
  always @(negedge clk) begin
    ctx_t c;
    if (!rst) begin
      if (cpu_ready) begin
        check("ready_expected", 256'(cq.size() != 0), 256'(1));
        if (cq.size() != 0) begin
          c = cq.pop_front();
          if (c.ld) check("cpu_rdata", 256'(cpu_rdata), 256'(c.d));
        end
      end
      if (flush_done) begin
        check("flush_done_expected", 256'(fpend > 0), 256'(1));
        if (fpend > 0) fpend--;
      end
    end
  end
  // memory responder: random ack latency, stray acks while idle, stability tracking
  initial forever begin
    mtx_t t;
    bit cw, stable, aborted;
    logic [31:0] ca;
    logic [255:0] cd;
    int d, waited;
    @(negedge clk);
    mem_ack = 0;
    if (rst) continue;
    if (mem_req) begin
      check("mem_expected", 256'(mq.size() != 0), 256'(1));
      if (mq.size() != 0) begin
        t = mq.pop_front();
        check("mem_we", 256'(mem_we), 256'(t.we));
        check("mem_addr", 256'(mem_addr), 256'(t.a));
        if (t.we) check("mem_wdata", mem_wdata, t.d);
      end
      cw = mem_we; ca = mem_addr; cd = mem_wdata;
      d = fixed_delay >= 0 ? fixed_delay : int'($urandom_range(0, 3));
      waited = 0; stable = 1; aborted = 0;
      while ((waited < d || stall) && !aborted) begin
        @(negedge clk);
        if (rst) aborted = 1;
        else begin
          waited++;
          if (mem_req !== 1'b1 || mem_we !== cw || mem_addr !== ca || mem_wdata !== cd) stable = 0;
        end
      end
      if (!aborted) begin
        check("mem_stable", 256'(stable), 256'(1));
        if (cw) begin rmem[ca] = cd; wr_cnt++; end
        mem_rdata = rmem.exists(ca) ? rmem[ca] : init_line(ca);
        mem_ack = 1;
      end
    end else if ($urandom_range(0, 7) == 0) mem_ack = 1;
  end
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int c, w0;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    check("rst_cpu_ready", 256'(cpu_ready), 256'(0));
    check("rst_cpu_busy", 256'(cpu_busy), 256'(0));
    check("rst_flush_done", 256'(flush_done), 256'(0));
    check("rst_mem_req", 256'(mem_req), 256'(0));
    check("rst_mem_we", 256'(mem_we), 256'(0));
    check("rst_cpu_rdata", 256'(cpu_rdata), 256'(0));
    check("rst_mem_addr", 256'(mem_addr), 256'(0));
    check("rst_mem_wdata", mem_wdata, 256'(0));
    check("rst_hit_cnt", 256'(hit_cnt), 256'(0));
    check("rst_miss_cnt", 256'(miss_cnt), 256'(0));
    model_reset();
    rst = 0;
    @(negedge clk);
    op(0, 32'h40, 0, c);
    op(0, 32'h44, 0, c);
    check("hit_latency", 256'(c), 256'(3));
    op(1, 32'h48, 32'hDEADBEEF, c);
    op(0, 32'h48, 0, c);
    op(0, 32'h440, 0, c);
    op(1, 32'h60, 32'hCAFE0003, c);
    op(1, 32'hE0, 32'hCAFE0007, c);
    w0 = wr_cnt;
    do_flush(c);
    check("flush_writes", 256'(wr_cnt - w0), 256'(2));
    w0 = wr_cnt;
    do_flush(c);
    check("flush2_writes", 256'(wr_cnt - w0), 256'(0));
    check("flush2_latency", 256'(c), 256'(NL + 1));
    op(0, 32'h60, 0, c);
    fixed_delay = 5;
    fork
      op(0, 32'h840, 0, c);
      begin
        repeat (3) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
          cpu_req = 1;
          check("busy_during_wait", 256'(cpu_busy), 256'(1));
          @(negedge clk);
          cpu_req = 0;
          check("busy_during_wait", 256'(cpu_busy), 256'(1));
          @(negedge clk);
        end
      end
    join
    fixed_delay = -1;
    stall = 1;
    model_access(0, 32'h44, 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h44;
    @(negedge clk);
    cpu_req = 0;
    for (int g = 0; g < 50 && !(mem_req && !mem_we); g++) @(negedge clk);
    check("refill_pending", 256'(mem_req && !mem_we), 256'(1));
    #1 rst = 1;
    #1;
    check("rst_async_mem_req", 256'(mem_req), 256'(0));
    check("rst_async_busy", 256'(cpu_busy), 256'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst2_hit_cnt", 256'(hit_cnt), 256'(0));
    check("rst2_miss_cnt", 256'(miss_cnt), 256'(0));
    rst = 0; stall = 0;
    @(negedge clk);
    op(0, 32'h44, 0, c);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 24) == 0) do_flush(c);
      else begin
        a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 5) | ($urandom_range(0, 7) << 2);
        op(1'($urandom_range(0, 1)), a, $urandom, c);
      end
    end
    do_flush(c);
    repeat (4) @(negedge clk);
    check("mem_queue_drained", 256'(mq.size()), 256'(0));
    check("cpu_queue_drained", 256'(cq.size()), 256'(0));
    check("flush_queue_drained", 256'(fpend), 256'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
